// File: rtl/butterfly_pkg.sv
// rtl/butterfly_pkg.sv - shared constants, mode enum and modular add/sub helpers
package butterfly_pkg;

   localparam int BFLY_LAT = 3;

   typedef enum logic {
      MODE_NTT  = 1'b0,
      MODE_INTT = 1'b1
   } bfly_mode_e;

   // Operands are expected in [0, q-1]; the caller narrows the 32-bit result.
   function automatic logic [31:0] addmod(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] q);
      logic [31:0] s;
      s = a + b;
      return (s >= q) ? (s - q) : s;
   endfunction

   function automatic logic [31:0] submod(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] q);
      return (a >= b) ? (a - b) : (a + q - b);
   endfunction

endpackage

// File: rtl/butterfly_pe_if.sv
// rtl/butterfly_pe_if.sv - operand/result handshake bundle for the butterfly element
interface butterfly_pe_if #(
   parameter int N = 9
);
   logic         in_valid;
   logic         in_ready;
   logic         mode;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic [N-1:0] w;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] x;
   logic [N-1:0] y;

   modport master (
      output in_valid, mode, a, b, w, out_ready,
      input  in_ready, out_valid, x, y
   );

   modport slave (
      input  in_valid, mode, a, b, w, out_ready,
      output in_ready, out_valid, x, y
   );
endinterface

// File: rtl/butterfly_pe_modmul_q.sv
// rtl/butterfly_pe_modmul_q.sv - modmul_q: registered 2N-bit product, reduced mod Q on the way out
module modmul_q #(
   parameter int N = 9,
   parameter int Q = 257
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] r
);
   localparam logic [2*N-1:0] QW = (2*N)'(Q);

   logic [2*N-1:0] prod;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prod <= '0;
      end else if (en) begin
         prod <= {{N{1'b0}}, a} * {{N{1'b0}}, b};
      end
   end

   assign r = N'(prod % QW);

endmodule

// File: rtl/butterfly_pe.sv
// rtl/butterfly_pe.sv - 3-stage NTT/INTT butterfly with one shared modular multiplier
// Optional BUTTERFLY_PE_HALF_EN: INTT results are scaled by 2^-1 mod Q in the last stage.
module butterfly_pe #(
   parameter int N = 9,
   parameter int Q = 257
) (
   input  logic           clk,
   input  logic           rst,
   butterfly_pe_if.slave  bus
);
   import butterfly_pkg::*;

   logic                adv;
   logic [BFLY_LAT-1:0] vld;
   bfly_mode_e          mode_in;
   logic [N-1:0]        sum_in;
   logic [N-1:0]        dif_in;
   logic [N-1:0]        mul_b;
   logic [N-1:0]        prod_r;

   bfly_mode_e          m1;
   logic [N-1:0]        a1;
   logic [N-1:0]        s1;
   bfly_mode_e          m2;
   logic [N-1:0]        a2;
   logic [N-1:0]        s2;
   logic [N-1:0]        t2;
   logic [N-1:0]        x_q;
   logic [N-1:0]        y_q;
   logic [N-1:0]        x_nxt;
   logic [N-1:0]        y_nxt;

   // The whole pipe moves as one; it only freezes when a result is waiting downstream.
   assign adv           = !(vld[BFLY_LAT-1] && !bus.out_ready);
   assign bus.in_ready  = adv;
   assign bus.out_valid = vld[BFLY_LAT-1];
   assign bus.x         = x_q;
   assign bus.y         = y_q;

   assign mode_in = bfly_mode_e'(bus.mode);
   assign sum_in  = N'(addmod(32'(bus.a), 32'(bus.b), 32'(Q)));
   assign dif_in  = N'(submod(32'(bus.a), 32'(bus.b), 32'(Q)));
   assign mul_b   = (mode_in == MODE_INTT) ? dif_in : bus.b;

   modmul_q #(.N(N), .Q(Q)) u_modmul (
      .clk (clk),
      .rst (rst),
      .en  (adv),
      .a   (bus.w),
      .b   (mul_b),
      .r   (prod_r)
   );

`ifdef BUTTERFLY_PE_HALF_EN
   function automatic logic [N-1:0] halfmod(input logic [N-1:0] v);
      logic [N:0] t;
      t = v[0] ? ({1'b0, v} + (N+1)'(Q)) : {1'b0, v};
      return t[N:1];
   endfunction
`endif

   always_comb begin
      x_nxt = s2;
      y_nxt = t2;
      if (m2 == MODE_NTT) begin
         x_nxt = N'(addmod(32'(a2), 32'(t2), 32'(Q)));
         y_nxt = N'(submod(32'(a2), 32'(t2), 32'(Q)));
      end
`ifdef BUTTERFLY_PE_HALF_EN
      else begin
         x_nxt = halfmod(s2);
         y_nxt = halfmod(t2);
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld <= '0;
         m1  <= MODE_NTT;
         a1  <= '0;
         s1  <= '0;
         m2  <= MODE_NTT;
         a2  <= '0;
         s2  <= '0;
         t2  <= '0;
         x_q <= '0;
         y_q <= '0;
      end else if (adv) begin
         vld <= {vld[BFLY_LAT-2:0], bus.in_valid};
         m1  <= mode_in;
         a1  <= bus.a;
         s1  <= sum_in;
         m2  <= m1;
         a2  <= a1;
         s2  <= s1;
         t2  <= prod_r;
         x_q <= x_nxt;
         y_q <= y_nxt;
      end
   end

endmodule

// File: tb/tb_butterfly_pe.sv
// tb/tb_butterfly_pe.sv - scoreboard bench for butterfly_pe (Q=257, N=9)
module tb_butterfly_pe;
   localparam int N = 9;
   localparam int Q = 257;
   localparam int LAT = 3;

   typedef struct packed {
      logic [N-1:0] x;
      logic [N-1:0] y;
   } exp_t;

   logic clk;
   logic rst;
   logic ready_req;
   logic rnd_en;
   logic rnd_ready;

   int   errors;
   int   checks;
   int   n_out;
   int   stall_cnt;
   exp_t sb[$];
   exp_t e;
   logic stalled_prev;
   logic [N-1:0] hx;
   logic [N-1:0] hy;

   butterfly_pe_if #(.N(N)) bus ();

   butterfly_pe #(.N(N), .Q(Q)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign bus.out_ready = rnd_en ? rnd_ready : ready_req;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      #2;
      rnd_ready = ($urandom_range(3) != 0);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic int halfv(input int v);
      return (v % 2 == 0) ? v / 2 : (v + Q) / 2;
   endfunction

   function automatic exp_t model(input logic m, input int a, input int b, input int w);
      int t;
      int xv;
      int yv;
      exp_t r;
      if (!m) begin
         t  = (b * w) % Q;
         xv = (a + t) % Q;
         yv = (a - t + Q) % Q;
      end else begin
         xv = (a + b) % Q;
         yv = (((a - b + Q) % Q) * w) % Q;
`ifdef BUTTERFLY_PE_HALF_EN
         xv = halfv(xv);
         yv = halfv(yv);
`endif
      end
      r.x = xv[N-1:0];
      r.y = yv[N-1:0];
      return r;
   endfunction

   // Monitor: handshake rule, stall stability, and in-order scoreboard compare.
   always @(negedge clk) begin
      if (rst) begin
         stalled_prev = 1'b0;
      end else begin
         chk("in_ready_rule", 32'(bus.in_ready), 32'(!(bus.out_valid && !bus.out_ready)));
         if (stalled_prev) begin
            chk("stall_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_hold_x", 32'(bus.x), 32'(hx));
            chk("stall_hold_y", 32'(bus.y), 32'(hy));
         end
         stalled_prev = bus.out_valid && !bus.out_ready;
         if (stalled_prev) stall_cnt++;
         hx = bus.x;
         hy = bus.y;
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_out", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("sb_x", 32'(bus.x), 32'(e.x));
               chk("sb_y", 32'(bus.y), 32'(e.y));
               n_out++;
            end
         end
      end
   end

   task automatic send(input logic m, input int av, input int bv, input int wv);
      bit done;
      int guard;
      done = 0;
      guard = 0;
      bus.in_valid = 1'b1;
      bus.mode = m;
      bus.a = av[N-1:0];
      bus.b = bv[N-1:0];
      bus.w = wv[N-1:0];
      while (!done) begin
         @(negedge clk);
         if (bus.in_ready) begin
            sb.push_back(model(m, av, bv, wv));
            done = 1;
         end
         @(posedge clk);
         #1;
         guard++;
         if (!done && guard > 200) begin
            chk("send_timeout", 32'd1, 32'd0);
            done = 1;
         end
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (sb.size() != 0 && guard < 200) begin
         @(posedge clk);
         #1;
         guard++;
      end
      chk("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   // Sends one set into an empty pipe and checks out_valid appears exactly LAT cycles later.
   task automatic lat_case(input string tag, input logic m, input int av, input int bv,
                           input int wv, input int xe, input int ye);
      send(m, av, bv, wv);
      for (int k = 1; k < LAT - 1; k++) begin
         @(posedge clk);
         #1;
         chk({tag, "_early"}, 32'(bus.out_valid), 32'd0);
      end
      @(posedge clk);
      #1;
      chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_x"}, 32'(bus.x), 32'(xe));
      chk({tag, "_y"}, 32'(bus.y), 32'(ye));
      drain();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int base;
      errors = 0;
      checks = 0;
      n_out = 0;
      stall_cnt = 0;
      stalled_prev = 1'b0;
      rnd_en = 1'b0;
      ready_req = 1'b1;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.mode = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.w = '0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_x", 32'(bus.x), 32'd0);
      chk("rst_y", 32'(bus.y), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      lat_case("ntt_5_3_2", 1'b0, 5, 3, 2, 11, 256);
`ifdef BUTTERFLY_PE_HALF_EN
      lat_case("intt_5_3_2", 1'b1, 5, 3, 2, 4, 2);
      lat_case("intt_256_256_1", 1'b1, 256, 256, 1, 256, 0);
`else
      lat_case("intt_5_3_2", 1'b1, 5, 3, 2, 8, 4);
      lat_case("intt_256_256_1", 1'b1, 256, 256, 1, 255, 0);
`endif
      lat_case("ntt_zero_b", 1'b0, 100, 0, 77, 100, 100);

      // 8 back-to-back sets, alternating mode, downstream stalls cycles 4-6.
      base = n_out;
      begin
         int s0;
         s0 = stall_cnt;
         fork
            begin
               for (int i = 0; i < 8; i++)
                  send(i[0], 30 * i + 7, 250 - 13 * i, 3 + 31 * i);
            end
            begin
               repeat (4) @(posedge clk);
               #1;
               ready_req = 1'b0;
               repeat (3) @(posedge clk);
               #1;
               ready_req = 1'b1;
            end
         join
         drain();
         chk("stream_count", 32'(n_out - base), 32'd8);
         chk("stream_stalls", 32'(stall_cnt - s0), 32'd3);
      end

      // Reset with three sets in flight: nothing from them may ever emerge.
      send(1'b0, 1, 2, 3);
      send(1'b1, 4, 5, 6);
      send(1'b0, 7, 8, 9);
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("midrst_x", 32'(bus.x), 32'd0);
      sb.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         chk("post_rst_quiet", 32'(bus.out_valid), 32'd0);
      end
      lat_case("post_rst_ntt", 1'b0, 5, 3, 2, 11, 256);

      // Random traffic against the reference model.
      rnd_en = 1'b1;
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(3) == 0) begin
            @(posedge clk);
            #1;
         end
         send(1'($urandom_range(1)), int'($urandom_range(Q - 1)), int'($urandom_range(Q - 1)),
              int'($urandom_range(Q - 1)));
      end
      rnd_en = 1'b0;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
